// File: rtl/wb_arbiter.sv
// wb_arbiter
// Merges two result streams onto one register-file write port.
//   - ALU results are single-cycle, cannot be held off, and always win the port.
//   - Slow results (load/mul/div) are handshaked into a small circular FIFO.
//     The FIFO drains into the port on cycles when the ALU is idle.
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     ALU result, no backpressure
//   lsu_valid/lsu_ready           slow-path handshake
//   lsu_rd/lsu_data               slow-path result
//   rd_addr/wr_data/wr_en         registered register-file write port
//   stall_req                     advisory front-end stall, high while the FIFO is full
//   pending_mask                  bit r set while a buffered slow result targets xr
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic [4:0]  rd_addr,
  output logic [31:0] wr_data,
  output logic        wr_en,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg, count_next;
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          wr_en_reg, wr_en_next;
  logic [4:0]    rd_addr_reg, rd_addr_next;
  logic [31:0]   wr_data_reg, wr_data_next;

  logic          push, pop;
  logic [DEPTH-1:0] entry_valid;

  assign lsu_ready = (count_reg < FULL_COUNT);
  assign stall_req = (count_reg == FULL_COUNT);

  // Results for x0 are accepted but thrown away.
  assign push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  // An ALU result blocks the pop even when it targets x0 and writes nothing.
  assign pop  = !alu_valid && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Address and data hold their last written value when no write happens.
  always_comb begin
    wr_en_next   = 1'b0;
    rd_addr_next = rd_addr_reg;
    wr_data_next = wr_data_reg;
    if (alu_valid) begin
      if (alu_rd != 5'd0) begin
        wr_en_next   = 1'b1;
        rd_addr_next = alu_rd;
        wr_data_next = alu_data;
      end
    end else if (pop) begin
      wr_en_next   = 1'b1;
      rd_addr_next = rd_mem[head_reg];
      wr_data_next = data_mem[head_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      count_reg   <= count_next;
      wr_en_reg   <= wr_en_next;
      rd_addr_reg <= rd_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Storage needs no reset: only entries inside [head, head+count) are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= lsu_rd;
      data_mem[tail_reg] <= lsu_data;
    end
  end

  // An entry is live when its distance from head (mod DEPTH) is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PW-1:0] offset;
      assign offset          = PW'(gi) - head_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    end
  endgenerate

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask[rd_mem[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign wr_en   = wr_en_reg;
  assign rd_addr = rd_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Randomised and directed stimulus against a queue-based reference model of the
// write-back arbiter. One line is printed per register-file write.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  rd_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        stall_req;
  logic [31:0] pending_mask;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .rd_addr      (rd_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .stall_req    (stall_req),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered slow results in arrival order, plus the
  // expected registered write port.
  logic [36:0] q[$];
  logic        exp_wr_en;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i][36:32]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_outputs();
    check("wr_en",        {31'd0, wr_en},     {31'd0, exp_wr_en});
    check("rd_addr",      {27'd0, rd_addr},   {27'd0, exp_rd});
    check("wr_data",      wr_data,            exp_data);
    check("lsu_ready",    {31'd0, lsu_ready}, {31'd0, (q.size() < DEPTH)});
    check("stall_req",    {31'd0, stall_req}, {31'd0, (q.size() == DEPTH)});
    check("pending_mask", pending_mask,       model_mask());
  endtask

  // One cycle: check what the DUT shows now, drive new inputs, then advance
  // the model across the next rising edge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    int size_before;
    logic [36:0] e;
    @(negedge clk);
    check_outputs();
    if (exp_wr_en) $display("write x%0d <= 0x%08h", exp_rd, exp_data);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    @(posedge clk);
    size_before = q.size();
    if (av) begin
      exp_wr_en = (ard != 5'd0);
      if (ard != 5'd0) begin
        exp_rd   = ard;
        exp_data = ad;
      end
    end else if (size_before > 0) begin
      e = q.pop_front();
      exp_wr_en = 1'b1;
      exp_rd    = e[36:32];
      exp_data  = e[31:0];
    end else begin
      exp_wr_en = 1'b0;
    end
    if (lv && size_before < DEPTH && lrd != 5'd0) q.push_back({lrd, ld});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    check("rst_wr_en",     {31'd0, wr_en},     32'd0);
    check("rst_rd_addr",   {27'd0, rd_addr},   32'd0);
    check("rst_wr_data",   wr_data,            32'd0);
    check("rst_stall",     {31'd0, stall_req}, 32'd0);
    check("rst_mask",      pending_mask,       32'd0);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    q.delete();
    exp_wr_en = 1'b0; exp_rd = '0; exp_data = '0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    exp_wr_en = 1'b0; exp_rd = '0; exp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("init_wr_en",     {31'd0, wr_en},     32'd0);
    check("init_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("init_mask",      pending_mask,       32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // ALU only
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(); idle();
    // Slow only
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
    idle(); idle(); idle();
    // Contention: ALU held while two slow results fill the FIFO
    cycle(1'b1, 5'd1, 32'hA0, 1'b1, 5'd3, 32'h33);
    cycle(1'b1, 5'd2, 32'hA1, 1'b1, 5'd4, 32'h44);
    cycle(1'b1, 5'd1, 32'hA2, 1'b1, 5'd6, 32'h66);
    cycle(1'b1, 5'd2, 32'hA3, 1'b0, 5'd0, 32'd0);
    idle(); idle(); idle(); idle();
    // x0 filtering on both paths
    cycle(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 32'hBAD1);
    idle(); idle();
    // Same-rd ordering
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1);
    cycle(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h2);
    idle(); idle(); idle();
    // Reset with the FIFO full and an ALU result in flight
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'h10);
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'h11);
    cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    pulse_reset();
    idle(); idle(); idle();

    // Randomised traffic with varying ALU pressure and occasional resets
    for (int blk = 0; blk < 8; blk++) begin
      int alu_pct = $urandom_range(90, 10);
      for (int c = 0; c < 40; c++) begin
        logic       av  = ($urandom_range(99, 0) < alu_pct);
        logic       lv  = ($urandom_range(99, 0) < 50);
        logic [4:0] ard = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
        logic [4:0] lrd = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(12, 1));
        cycle(av, ard, $urandom, lv, lrd, $urandom);
      end
      if (blk % 3 == 2) pulse_reset();
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
